// File: rtl/axi_lite_ipif_bridge_pkg.sv
// Shared constants and FSM encoding for the AXI4-Lite to IPIF bridge.
package axi_lite_ipif_bridge_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int TO_CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_RRESP = 3'd3,
        ST_BRESP = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/axi_lite_ipif_timeout.sv
// Data-phase watchdog: counts cycles while enabled and flags the last allowed cycle.
module axi_lite_ipif_timeout
    import axi_lite_ipif_bridge_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(LIMIT - 1);

    logic [TO_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TO_CNT_W'(1);
        end
    end

    // LIMIT of zero turns the watchdog off entirely.
    assign expired = (LIMIT != 0) && enable && (count == LAST);

endmodule

// File: rtl/axi_lite_ipif_bridge.sv
// AXI4-Lite slave front end that runs one register access at a time over the IPIF strobe/ack interface.
module axi_lite_ipif_bridge
    import axi_lite_ipif_bridge_pkg::*;
#(
    parameter int                              C_S_AXI_DATA_WIDTH = 32,
    parameter int                              C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   C_BASEADDR         = 32'hFFFF_FFFF,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   C_HIGHADDR         = 32'h0000_0000,
    parameter int                              C_DPHASE_TIMEOUT   = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            Bus2IP_Clk,
    output logic                            Bus2IP_Resetn,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr,
    output logic                            Bus2IP_CS,
    output logic                            Bus2IP_RNW,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data,
    input  logic                            IP2Bus_RdAck,
    input  logic                            IP2Bus_WrAck,
    input  logic                            IP2Bus_Error
);

    bridge_state_t state;
    logic          rd_hit;
    logic          wr_hit;
    logic          to_clear;
    logic          to_expired;

    assign Bus2IP_Clk    = S_AXI_ACLK;
    assign Bus2IP_Resetn = ~S_AXI_ARESET;

    assign rd_hit   = (S_AXI_ARADDR >= C_BASEADDR) && (S_AXI_ARADDR <= C_HIGHADDR);
    assign wr_hit   = (S_AXI_AWADDR >= C_BASEADDR) && (S_AXI_AWADDR <= C_HIGHADDR);
    assign to_clear = (state != ST_RD) && (state != ST_WR);

    axi_lite_ipif_timeout #(
        .LIMIT (C_DPHASE_TIMEOUT)
    ) u_timeout (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .clear   (to_clear),
        .enable  (Bus2IP_CS),
        .expired (to_expired)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state         <= ST_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= AXI_RESP_OKAY;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= AXI_RESP_OKAY;
            S_AXI_RDATA   <= '0;
            Bus2IP_CS     <= 1'b0;
            Bus2IP_RNW    <= 1'b1;
            Bus2IP_Addr   <= '0;
            Bus2IP_Data   <= '0;
            Bus2IP_BE     <= '0;
        end else begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Reads take priority; a write needs both AW and W present together.
                    if (S_AXI_ARVALID) begin
                        Bus2IP_Addr   <= S_AXI_ARADDR - C_BASEADDR;
                        Bus2IP_RNW    <= 1'b1;
                        Bus2IP_CS     <= rd_hit;
                        S_AXI_ARREADY <= 1'b1;
                        state         <= ST_RD;
                    end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
                        Bus2IP_Addr   <= S_AXI_AWADDR - C_BASEADDR;
                        Bus2IP_Data   <= S_AXI_WDATA;
                        Bus2IP_BE     <= S_AXI_WSTRB;
                        Bus2IP_RNW    <= 1'b0;
                        Bus2IP_CS     <= wr_hit;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        state         <= ST_WR;
                    end
                end
                ST_RD: begin
                    // CS low here can only mean the address missed the decode window.
                    if (!Bus2IP_CS) begin
                        S_AXI_RDATA  <= '0;
                        S_AXI_RRESP  <= AXI_RESP_DECERR;
                        S_AXI_RVALID <= 1'b1;
                        state        <= ST_RRESP;
                    end else if (IP2Bus_RdAck) begin
                        Bus2IP_CS    <= 1'b0;
                        S_AXI_RDATA  <= IP2Bus_Data;
                        S_AXI_RRESP  <= IP2Bus_Error ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        S_AXI_RVALID <= 1'b1;
                        state        <= ST_RRESP;
                    end else if (to_expired) begin
                        Bus2IP_CS    <= 1'b0;
                        S_AXI_RDATA  <= '0;
                        S_AXI_RRESP  <= AXI_RESP_SLVERR;
                        S_AXI_RVALID <= 1'b1;
                        state        <= ST_RRESP;
                    end
                end
                ST_WR: begin
                    if (!Bus2IP_CS) begin
                        S_AXI_BRESP  <= AXI_RESP_DECERR;
                        S_AXI_BVALID <= 1'b1;
                        state        <= ST_BRESP;
                    end else if (IP2Bus_WrAck) begin
                        Bus2IP_CS    <= 1'b0;
                        S_AXI_BRESP  <= IP2Bus_Error ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        S_AXI_BVALID <= 1'b1;
                        state        <= ST_BRESP;
                    end else if (to_expired) begin
                        Bus2IP_CS    <= 1'b0;
                        S_AXI_BRESP  <= AXI_RESP_SLVERR;
                        S_AXI_BVALID <= 1'b1;
                        state        <= ST_BRESP;
                    end
                end
                ST_RRESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                ST_BRESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_ipif_bridge.sv
// Randomized bench for axi_lite_ipif_bridge against a transaction-level register-file model.
module tb_axi_lite_ipif_bridge;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] HIGH = 32'h4000_00FF;
    localparam int          TO   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        ip_clk, ip_resetn, ip_cs, ip_rnw;
    logic [31:0] ip_addr, ip_wdata;
    logic [3:0]  ip_be;
    logic [31:0] ip_rdata = '0;
    logic        ip_rdack = 1'b0, ip_wrack = 1'b0, ip_error = 1'b0;

    always #5 clk = ~clk;

    axi_lite_ipif_bridge #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .C_BASEADDR         (BASE),
        .C_HIGHADDR         (HIGH),
        .C_DPHASE_TIMEOUT   (TO)
    ) dut (
        .S_AXI_ACLK    (clk),      .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),   .S_AXI_AWVALID (awvalid), .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),    .S_AXI_WSTRB   (wstrb),   .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),   .S_AXI_BRESP   (bresp),   .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),   .S_AXI_ARADDR  (araddr),  .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),  .S_AXI_RDATA   (rdata),   .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),   .S_AXI_RREADY  (rready),
        .Bus2IP_Clk    (ip_clk),   .Bus2IP_Resetn (ip_resetn), .Bus2IP_Addr (ip_addr),
        .Bus2IP_CS     (ip_cs),    .Bus2IP_RNW    (ip_rnw),  .Bus2IP_Data   (ip_wdata),
        .Bus2IP_BE     (ip_be),    .IP2Bus_Data   (ip_rdata), .IP2Bus_RdAck (ip_rdack),
        .IP2Bus_WrAck  (ip_wrack), .IP2Bus_Error  (ip_error)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Register-file responder: registered acks, so a trailing ack follows CS falling.
    logic [31:0] rf_mem  [64];
    logic [31:0] ref_mem [64];
    int  ack_dly  = 0;
    bit  no_ack   = 0;
    bit  err_mode = 0;
    int  cs_cnt   = 0;
    logic ack_now;
    always @(posedge clk) begin
        ack_now = ip_cs && !no_ack && (cs_cnt >= ack_dly);
        cs_cnt   <= ip_cs ? cs_cnt + 1 : 0;
        ip_rdack <= ack_now && ip_rnw;
        ip_wrack <= ack_now && !ip_rnw;
        ip_error <= ack_now && err_mode;
        ip_rdata <= rf_mem[ip_addr[7:2]];
        if (ack_now && !ip_rnw && !err_mode)
            for (int b = 0; b < 4; b++)
                if (ip_be[b]) rf_mem[ip_addr[7:2]][8*b +: 8] <= ip_wdata[8*b +: 8];
    end

    int cs_cycles = 0, cs_phases = 0, aw_pulses = 0, ar_pulses = 0;
    logic cs_prev = 1'b0;
    logic [31:0] cap_addr = '0, cap_data = '0;
    logic [3:0]  cap_be = '0;
    logic        cap_rnw = 1'b0;
    always @(negedge clk) begin
        if (ip_cs) begin
            cs_cycles++;
            if (!cs_prev) begin
                cs_phases++;
                cap_addr = ip_addr; cap_data = ip_wdata; cap_be = ip_be; cap_rnw = ip_rnw;
            end
        end
        cs_prev = ip_cs;
        if (awready) aw_pulses++;
        if (arready) ar_pulses++;
    end

    task automatic issue_rd(input logic [31:0] a);
        @(negedge clk);
        araddr = a; arvalid = 1'b1; t0 = cyc;
    endtask

    task automatic issue_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = be; awvalid = 1'b1; wvalid = 1'b1; t0 = cyc;
    endtask

    task automatic wait_hs(input bit is_rd, input bit tchk);
        int n = 0;
        forever begin
            @(negedge clk); n++;
            if (is_rd ? arready : awready) break;
            if (n > 200) begin chk("hs_timeout", 0, 1); break; end
        end
        if (tchk) chk("ready_latency", n, 1);
        if (!is_rd) chk("wready_with_awready", wready, 1);
        @(posedge clk); #1;
        if (is_rd) arvalid = 1'b0;
        else begin awvalid = 1'b0; wvalid = 1'b0; end
    endtask

    task automatic finish(input bit is_rd, input logic [31:0] ed, input logic [1:0] er,
                          input int hold, input bit tchk, input int evl);
        int n = 0;
        forever begin
            @(negedge clk); n++;
            if (is_rd ? rvalid : bvalid) break;
            if (n > 200) begin chk("valid_timeout", 0, 1); break; end
        end
        if (tchk) chk("valid_latency", cyc - t0, evl);
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) @(negedge clk);
            if (is_rd) begin
                chk("rvalid_held", rvalid, 1); chk("rdata", rdata, ed); chk("rresp", rresp, er);
            end else begin
                chk("bvalid_held", bvalid, 1); chk("bresp", bresp, er);
            end
        end
        if (is_rd) rready = 1'b1; else bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        @(negedge clk);
        chk("valid_dropped", is_rd ? rvalid : bvalid, 0);
    endtask

    // Expected outcome straight from the address window, responder behaviour and timeout rule.
    task automatic do_txn(input bit is_rd, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input int hold);
        bit hit   = (a >= BASE) && (a <= HIGH);
        bit acked = !no_ack && (ack_dly + 2 <= TO);
        int idx   = int'((a - BASE) >> 2) & 63;
        logic [31:0] ed = '0;
        logic [1:0]  er;
        int ecs, evl;
        bit upd = 0;
        if (!hit) begin er = 2'b11; ecs = 0; evl = 2; end
        else if (!acked) begin er = 2'b10; ecs = TO; evl = TO + 1; end
        else begin
            er = err_mode ? 2'b10 : 2'b00; ecs = ack_dly + 2; evl = ack_dly + 3;
            if (is_rd) ed = ref_mem[idx]; else upd = !err_mode;
        end
        cs_cycles = 0; cs_phases = 0;
        if (is_rd) issue_rd(a); else issue_wr(a, d, be);
        wait_hs(is_rd, 1);
        finish(is_rd, ed, er, hold, 1, evl);
        @(negedge clk); #1;
        chk("cs_cycles", cs_cycles, ecs);
        if (ecs > 0) begin
            chk("ip_addr", cap_addr, a - BASE);
            chk("ip_rnw", cap_rnw, is_rd);
            if (!is_rd) begin chk("ip_wdata", cap_data, d); chk("ip_be", cap_be, be); end
        end
        if (upd)
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            rf_mem[i]  = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end
        rf_mem[1] = 32'h1234_5678; ref_mem[1] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        chk("rst_resetn", ip_resetn, 0);
        chk("rst_readys", {awready, wready, arready}, 0);
        chk("rst_valids", {bvalid, rvalid}, 0);
        chk("rst_resps", {bresp, rresp}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_cs_rnw", {ip_cs, ip_rnw}, 2'b01);
        chk("rst_addr_data_be", {ip_addr, ip_wdata, ip_be}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("resetn_high", ip_resetn, 1);

        // Directed: basic write, held read, boundaries.
        do_txn(0, BASE + 8, 32'hA5A5_0001, 4'hF, 0);
        do_txn(1, BASE + 8, '0, '0, 0);
        do_txn(1, BASE + 4, '0, '0, 5);
        do_txn(1, HIGH + 4, '0, '0, 1);
        do_txn(1, HIGH + 1, '0, '0, 0);
        do_txn(1, HIGH, '0, '0, 0);
        do_txn(0, BASE - 4, 32'hDEAD_BEEF, 4'hF, 0);

        // AW alone must never be accepted.
        aw_pulses = 0;
        @(negedge clk); awaddr = BASE; awvalid = 1'b1;
        repeat (10) @(negedge clk);
        chk("aw_only_no_ready", aw_pulses, 0);
        awvalid = 1'b0;

        // Read and write presented together: read first, one CS phase each.
        cs_phases = 0; aw_pulses = 0;
        @(negedge clk);
        araddr = BASE + 4; arvalid = 1'b1;
        awaddr = BASE + 12; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        t0 = cyc;
        wait_hs(1, 1);
        chk("both_no_awready_yet", aw_pulses, 0);
        finish(1, ref_mem[1], 2'b00, 0, 1, 3);
        chk("both_first_phase_read", {cs_phases[1:0], cap_rnw}, {2'd1, 1'b1});
        wait_hs(0, 0);
        finish(0, '0, 2'b00, 0, 0, 0);
        @(negedge clk); #1;
        chk("both_two_phases", cs_phases, 2);
        chk("both_write_addr", cap_addr, 32'd12);
        ref_mem[3] = 32'h0BAD_F00D;
        do_txn(1, BASE + 12, '0, '0, 0);

        // Timeout, ack on the timeout cycle, error acks.
        no_ack = 1;
        do_txn(1, BASE + 4, '0, '0, 0);
        do_txn(0, BASE + 16, 32'h5555_AAAA, 4'hF, 0);
        no_ack = 0;
        ack_dly = TO - 2;
        do_txn(1, BASE + 4, '0, '0, 0);
        ack_dly = TO - 1;
        do_txn(1, BASE + 4, '0, '0, 0);
        ack_dly = 0;
        err_mode = 1;
        do_txn(0, BASE + 20, 32'h7777_7777, 4'hF, 0);
        do_txn(1, BASE + 20, '0, '0, 0);
        err_mode = 0;

        // Reset while the write data phase is open.
        ack_dly = 5;
        issue_wr(BASE + 24, 32'hCAFE_0000, 4'hF);
        wait_hs(0, 1);
        @(negedge clk);
        chk("midrst_cs_before", ip_cs, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cs", ip_cs, 0);
        chk("midrst_bvalid", bvalid, 0);
        chk("midrst_readys", {awready, wready, arready}, 0);
        chk("midrst_rnw", ip_rnw, 1);
        rst = 1'b0;
        ack_dly = 0;
        do_txn(1, BASE + 24, '0, '0, 0);

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            int r = $urandom_range(0, 9);
            logic [31:0] a;
            if (r == 0)      a = HIGH + 32'($urandom_range(1, 64));
            else if (r == 1) a = BASE - 32'($urandom_range(1, 64));
            else             a = BASE + 32'($urandom_range(0, 63) << 2);
            ack_dly  = $urandom_range(0, 3);
            err_mode = ($urandom_range(0, 9) == 0);
            no_ack   = ($urandom_range(0, 19) == 0);
            do_txn($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(1, 15)),
                   $urandom_range(0, 3));
        end
        no_ack = 0; err_mode = 0; ack_dly = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
